// File: rtl/apb_rev_b_pkg.sv
// Shared types, bus widths and the address decoder for the APB rev B register bank.
package apb_rev_b_pkg;
  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;
  localparam int MAX_REGS   = 64;
  localparam int IDX_W      = 6;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             err;
  } decode_t;

  // idx is only meaningful when err is clear.
  function automatic decode_t decode(input logic [APB_ADDR_W-1:0] addr,
                                     input logic                  write,
                                     input logic [APB_ADDR_W-1:0] base,
                                     input int                    num_regs,
                                     input logic [MAX_REGS-1:0]   ro_mask);
    logic [APB_ADDR_W-1:0] off;
    decode_t               d;
    off   = addr - base;
    d.idx = off[IDX_W+1:2];
    d.err = (addr[1:0] != 2'b00) || (addr < base) || (off >= 32'(num_regs * 4));
    if (!d.err && write && ro_mask[d.idx]) d.err = 1'b1;
    return d;
  endfunction
endpackage

// File: rtl/apb_rev_b_completer_fsm.sv
// APB completer sequencing: setup/access FSM, wait-state counter and address/direction latch.
module apb_rev_b_completer_fsm
  import apb_rev_b_pkg::*;
#(
  parameter int WAIT_STATES = 0
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic [APB_ADDR_W-1:0] paddr,
  input  logic                  pselx,
  input  logic                  penable,
  input  logic                  pwrite,
  output logic                  pready,
  output logic                  ack,
  output logic [APB_ADDR_W-1:0] addr_q,
  output logic                  write_q,
  output state_e                state_dbg
);
  state_e                state, state_d;
  logic [3:0]            wait_cnt, wait_cnt_d;
  logic [APB_ADDR_W-1:0] addr_d;
  logic                  write_d;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state    <= IDLE;
      wait_cnt <= '0;
      addr_q   <= '0;
      write_q  <= 1'b0;
    end else begin
      state    <= state_d;
      wait_cnt <= wait_cnt_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
    end
  end

  // pready is only raised while the master still selects us, so an abort never completes.
  always_comb begin
    state_d    = state;
    wait_cnt_d = wait_cnt;
    addr_d     = addr_q;
    write_d    = write_q;
    pready     = 1'b0;
    case (state)
      IDLE: begin
        if (pselx && !penable) begin
          state_d    = ACCESS;
          addr_d     = paddr;
          write_d    = pwrite;
          wait_cnt_d = 4'(WAIT_STATES);
        end
      end
      ACCESS: begin
        if (!pselx) begin
          state_d = IDLE;
        end else if (wait_cnt == 4'd0) begin
          pready  = 1'b1;
          state_d = IDLE;
        end else begin
          wait_cnt_d = wait_cnt - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ack       = pready;
  assign state_dbg = state;
endmodule

// File: rtl/apb_rev_b_regbank.sv
// APB rev B completer terminating in a bank of 32-bit registers with optional read-only status slots.
module apb_rev_b_regbank
  import apb_rev_b_pkg::*;
#(
  parameter int                  NUM_REGS    = 8,
  parameter logic [31:0]         BASE_ADDR   = 32'h0000_0000,
  parameter int                  WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0] RO_MASK     = '0
) (
  input  logic                     pclk,
  input  logic                     presetn,
  input  logic [APB_ADDR_W-1:0]    paddr,
  input  logic                     pselx,
  input  logic                     penable,
  input  logic                     pwrite,
  input  logic [APB_DATA_W-1:0]    pwdata,
  output logic                     pready,
  output logic [APB_DATA_W-1:0]    prdata,
  output logic                     pslverr,
  output logic [NUM_REGS*32-1:0]   reg_q,
  input  logic [NUM_REGS*32-1:0]   ro_d,
  output logic [NUM_REGS-1:0]      wr_pulse
);
  localparam int IDX_LW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  // Handshake: a transfer completes on the single rising edge where pselx, penable and
  // pready are all high; prdata and pslverr are only meaningful in that cycle and 0 otherwise.
  logic                  ack;
  logic [APB_ADDR_W-1:0] addr_q;
  logic                  write_q;
  state_e                fsm_state_unused;
  decode_t               dec;
  logic [IDX_W-1:0]      dec_idx_unused;
  logic [IDX_LW-1:0]     idx;
  logic                  commit;
  logic [31:0]           regs   [NUM_REGS];
  logic [31:0]           ro_arr [NUM_REGS];

  apb_rev_b_completer_fsm #(
    .WAIT_STATES (WAIT_STATES)
  ) u_fsm (
    .pclk      (pclk),
    .presetn   (presetn),
    .paddr     (paddr),
    .pselx     (pselx),
    .penable   (penable),
    .pwrite    (pwrite),
    .pready    (pready),
    .ack       (ack),
    .addr_q    (addr_q),
    .write_q   (write_q),
    .state_dbg (fsm_state_unused)
  );

  assign dec            = decode(addr_q, write_q, BASE_ADDR, NUM_REGS, 64'(RO_MASK));
  assign dec_idx_unused = dec.idx;
  assign idx            = dec.idx[IDX_LW-1:0];
  assign commit         = ack && write_q && !dec.err;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_slice
    assign ro_arr[i]           = ro_d[32*i +: 32];
    assign reg_q[32*i +: 32]   = RO_MASK[i] ? 32'h0 : regs[i];
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      wr_pulse <= '0;
    end else begin
      wr_pulse <= '0;
      if (commit) begin
        regs[idx]     <= pwdata;
        wr_pulse[idx] <= 1'b1;
      end
    end
  end

  always_comb begin
    prdata = '0;
    if (ack && !dec.err) prdata = RO_MASK[idx] ? ro_arr[idx] : regs[idx];
  end

  assign pslverr = ack && dec.err;
endmodule

// File: tb/tb_apb_rev_b_regbank.sv
// Bench for apb_rev_b_regbank: a zero-wait and a three-wait instance checked against an array model.
module tb_apb_rev_b_regbank;
  localparam int          NR   = 8;
  localparam logic [31:0] BASE = 32'h0000_4000;
  localparam int          RO_I = 7;

  logic            pclk = 1'b0;
  logic            presetn;
  logic [31:0]     paddr, pwdata;
  logic            penable, pwrite;
  logic [1:0]      psel;
  logic [NR*32-1:0] ro_d;

  logic            pready0, pslverr0, pready1, pslverr1;
  logic [31:0]     prdata0, prdata1;
  logic [NR*32-1:0] reg_q0, reg_q1;
  logic [NR-1:0]   wr_pulse0, wr_pulse1;

  logic [31:0]     mdl [2][NR];
  logic [31:0]     exp_q [$];
  int              n_checks = 0;
  int              n_pass   = 0;

  // ---------------- clock / reset ----------------
  always #5 pclk = ~pclk;

  apb_rev_b_regbank #(.NUM_REGS(NR), .BASE_ADDR(BASE), .WAIT_STATES(0), .RO_MASK(8'h80)) u_dut0 (
    .pclk(pclk), .presetn(presetn), .paddr(paddr), .pselx(psel[0]), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pready(pready0), .prdata(prdata0), .pslverr(pslverr0),
    .reg_q(reg_q0), .ro_d(ro_d), .wr_pulse(wr_pulse0));

  apb_rev_b_regbank #(.NUM_REGS(NR), .BASE_ADDR(BASE), .WAIT_STATES(3), .RO_MASK(8'h80)) u_dut1 (
    .pclk(pclk), .presetn(presetn), .paddr(paddr), .pselx(psel[1]), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pready(pready1), .prdata(prdata1), .pslverr(pslverr1),
    .reg_q(reg_q1), .ro_d(ro_d), .wr_pulse(wr_pulse1));

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic logic cur_pready(input int d);
    return d != 0 ? pready1 : pready0;
  endfunction
  function automatic logic cur_pslverr(input int d);
    return d != 0 ? pslverr1 : pslverr0;
  endfunction
  function automatic logic [31:0] cur_prdata(input int d);
    return d != 0 ? prdata1 : prdata0;
  endfunction
  function automatic logic [NR-1:0] cur_pulse(input int d);
    return d != 0 ? wr_pulse1 : wr_pulse0;
  endfunction
  function automatic logic [31:0] cur_slice(input int d, input int i);
    logic [NR*32-1:0] q;
    q = (d != 0) ? reg_q1 : reg_q0;
    return q[32*i +: 32];
  endfunction

  function automatic logic exp_err(input logic [31:0] a, input logic wr);
    if (a[1:0] != 2'b00) return 1'b1;
    if (a < BASE) return 1'b1;
    if ((a - BASE) >= 32'(NR * 4)) return 1'b1;
    if (wr && ((a - BASE) / 4) == RO_I) return 1'b1;
    return 1'b0;
  endfunction

  task automatic clear_model();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < NR; i++) mdl[d][i] = 32'h0;
  endtask

  task automatic check_regs(input int d, input string tag);
    for (int i = 0; i < NR; i++)
      check({tag, "/reg_q"}, cur_slice(d, i), (i == RO_I) ? 32'h0 : mdl[d][i]);
  endtask

  // ---------------- driver tasks ----------------
  // Entered and left 1 time unit after a rising edge; the next call may set up immediately.
  task automatic xfer(input int d, input logic [31:0] a, input logic wr,
                      input logic [31:0] wd, input string tag);
    int           waits;
    int           idx;
    logic         e;
    logic [NR-1:0] exp_pulse;
    e   = exp_err(a, wr);
    idx = e ? 0 : int'((a - BASE) >> 2);
    if (!wr) exp_q.push_back(e ? 32'h0 : (idx == RO_I ? ro_d[32*RO_I +: 32] : mdl[d][idx]));
    paddr = a; pwrite = wr; pwdata = wd; penable = 1'b0;
    psel = 2'b00; psel[d] = 1'b1;
    @(posedge pclk); #1 penable = 1'b1;
    waits = 0;
    forever begin
      @(negedge pclk);
      if (cur_pready(d) || waits > 40) break;
      check({tag, "/wait_prdata"}, cur_prdata(d), 32'h0);
      check({tag, "/wait_pslverr"}, 32'(cur_pslverr(d)), 32'h0);
      waits++;
      @(posedge pclk); #1;
    end
    check({tag, "/pready"}, 32'(cur_pready(d)), 32'h1);
    check({tag, "/wait_states"}, 32'(waits), (d != 0) ? 32'd3 : 32'd0);
    check({tag, "/pslverr"}, 32'(cur_pslverr(d)), 32'(e));
    if (!wr) check({tag, "/prdata"}, cur_prdata(d), exp_q.pop_front());
    @(posedge pclk); #1;
    psel = 2'b00; penable = 1'b0;
    exp_pulse = '0;
    if (wr && !e) begin
      mdl[d][idx]    = wd;
      exp_pulse[idx] = 1'b1;
    end
    check({tag, "/wr_pulse"}, 32'(cur_pulse(d)), 32'(exp_pulse));
    if (!e) check({tag, "/reg_q_idx"}, cur_slice(d, idx), (idx == RO_I) ? 32'h0 : mdl[d][idx]);
  endtask

  task automatic abort_write(input int d, input logic [31:0] a, input logic [31:0] wd);
    paddr = a; pwrite = 1'b1; pwdata = wd; penable = 1'b0;
    psel = 2'b00; psel[d] = 1'b1;
    @(posedge pclk); #1 penable = 1'b1;
    @(posedge pclk); #1 psel = 2'b00; penable = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge pclk);
      check("abort/pready", 32'(cur_pready(d)), 32'h0);
      check("abort/wr_pulse", 32'(cur_pulse(d)), 32'h0);
    end
    @(posedge pclk); #1;
    check_regs(d, "abort");
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] a;
    presetn = 1'b0; psel = 2'b00; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; ro_d = '0;
    clear_model();
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    for (int d = 0; d < 2; d++) begin
      check("reset/pready", 32'(cur_pready(d)), 32'h0);
      check("reset/pslverr", 32'(cur_pslverr(d)), 32'h0);
      check("reset/prdata", cur_prdata(d), 32'h0);
      check("reset/wr_pulse", 32'(cur_pulse(d)), 32'h0);
      check_regs(d, "reset");
    end
    @(posedge pclk); #1 presetn = 1'b1;

    // directed: basic write/read, wait states, errors, read-only slot
    xfer(0, 32'h4008, 1'b1, 32'hDEAD_BEEF, "w0_4008");
    xfer(0, 32'h4008, 1'b0, 32'h0, "r0_4008");
    xfer(1, 32'h4000, 1'b0, 32'h0, "r1_4000");
    xfer(0, 32'h4020, 1'b0, 32'h0, "r0_oor");
    xfer(0, 32'h4002, 1'b1, 32'h1111_2222, "w0_unal");
    xfer(0, 32'h401C, 1'b1, 32'h3333_4444, "w0_ro");
    xfer(0, 32'h3FFC, 1'b0, 32'h0, "r0_below");
    ro_d[32*RO_I +: 32] = 32'h1234_5678;
    xfer(0, 32'h401C, 1'b0, 32'h0, "r0_ro");
    check_regs(0, "directed");

    abort_write(1, 32'h4004, 32'h55AA_55AA);
    xfer(1, 32'h4004, 1'b1, 32'hA5A5_0001, "w1_after_abort");
    xfer(1, 32'h4004, 1'b0, 32'h0, "r1_after_abort");

    // reset in the middle of a write access; bus left selected with penable high
    paddr = 32'h4010; pwrite = 1'b1; pwdata = 32'hCAFE_F00D; penable = 1'b0; psel = 2'b10;
    @(posedge pclk); #1 penable = 1'b1;
    @(negedge pclk); presetn = 1'b0;
    #1;
    clear_model();
    check("midreset/pready", 32'(pready1), 32'h0);
    check_regs(1, "midreset");
    check_regs(0, "midreset");
    @(posedge pclk); #1 presetn = 1'b1;
    repeat (2) begin
      @(negedge pclk);
      check("noset/pready", 32'(pready1), 32'h0);
    end
    @(posedge pclk); #1 psel = 2'b00; penable = 1'b0;
    check("noset/wr_pulse", 32'(wr_pulse1), 32'h0);
    xfer(1, 32'h4010, 1'b0, 32'h0, "r1_post_reset");

    // back-to-back over every register on both instances
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < NR; i++) xfer(d, BASE + 32'(4 * i), 1'b1, $urandom(), "b2b_w");
      for (int i = 0; i < NR; i++) xfer(d, BASE + 32'(4 * i), 1'b0, 32'h0, "b2b_r");
    end

    // random mix
    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < NR; i++) ro_d[32*i +: 32] = $urandom();
      case ($urandom_range(0, 9))
        0:       a = BASE + 32'(NR * 4) + 32'(4 * $urandom_range(0, 15));
        1:       a = BASE + 32'($urandom_range(0, NR * 4 - 1));
        2:       a = BASE - 32'(4 * $urandom_range(1, 4));
        default: a = BASE + 32'(4 * $urandom_range(0, NR - 1));
      endcase
      xfer(int'($urandom_range(0, 1)), a, 1'($urandom_range(0, 1)), $urandom(), "rand");
    end
    check_regs(0, "final");
    check_regs(1, "final");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
